pwm_fade_sequencer: RTL and testbench
=====================================

# pwm_fade_sequencer

Duty-cycle envelope generator that sits directly upstream of the PWM core and drives its `duty_cycle` input. It produces a trapezoidal "breathing" profile (ramp up, hold high, ramp down, hold low) between programmable limits. All duty updates are aligned to the PWM core's period-start pulse, so the core never sees a mid-period change. Ramp rate, step size and hold times are runtime inputs, latched at defined safe points.

## Interface
- `DUTY_W`, 16, width of duty and limit values (matches the PWM core's `duty_cycle`)
- `CNT_W`, 8, width of step, prescale and hold inputs

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `enable`  in  1  level; 1 runs the envelope, 0 returns to IDLE at the next period boundary
- `period_start`  in  1  one-cycle pulse from the PWM core at the first clock of each PWM period
- `duty_min`  in  DUTY_W  lower envelope limit
- `duty_max`  in  DUTY_W  upper envelope limit
- `step`  in  CNT_W  duty increment/decrement per tick; 0 is treated as 1
- `periods_per_tick`  in  CNT_W  PWM periods per envelope tick; 0 is treated as 1
- `hold_high`  in  CNT_W  ticks spent at `duty_max`; 0 skips HOLD_HI
- `hold_low`  in  CNT_W  ticks spent at `duty_min`; 0 skips HOLD_LO
- `duty`  out  DUTY_W  registered duty value to the PWM core
- `direction`  out  1  1 in RAMP_UP and HOLD_HI, 0 otherwise
- `state`  out  3  IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4
- `cycle_done`  out  1  one-cycle pulse when RAMP_DN reaches `duty_min`

## Operation
- **Reset values:** `duty`=0, `state`=IDLE, `direction`=0, `cycle_done`=0; prescaler, hold counter and config latches are all 0.
- **Config latching:** `duty_min`, `duty_max`, `step`, `periods_per_tick`, `hold_high` and `hold_low` are latched on IDLE exit and on every `cycle_done`. Changes at any other time have no effect until the next latch point.
- **Prescaler:**
  - Counts `period_start` pulses.
  - When the count equals max(`periods_per_tick`,1)-1 and `period_start`=1, it asserts the internal `tick` and clears.
  - It is cleared on IDLE exit.
- **IDLE:** `duty` holds its value. When `enable`=1 and `period_start`=1: latch config, set `duty`=`duty_min`, go to RAMP_UP.
- **RAMP_UP, on tick:**
  - Compute `duty`+`step` at DUTY_W+1 bits.
  - If the sum is >= `duty_max`: set `duty`=`duty_max`, clear the hold counter, go to HOLD_HI (or to RAMP_DN if `hold_high`=0).
  - Otherwise: `duty` += `step`.
- **HOLD_HI, on tick:** if hold counter = `hold_high`-1, go to RAMP_DN; else increment the counter. `duty` is unchanged.
- **RAMP_DN, on tick:**
  - Test `duty` <= `duty_min`+`step`, computed at DUTY_W+1 bits so there is no underflow.
  - If true: set `duty`=`duty_min`, pulse `cycle_done`, latch config, clear the hold counter, go to HOLD_LO (or to RAMP_UP if `hold_low`=0).
  - Otherwise: `duty` -= `step`.
- **HOLD_LO, on tick:** if hold counter = `hold_low`-1, go to RAMP_UP; else increment the counter.
- **Disable:** `enable`=0 in any non-IDLE state, at the next `period_start` sets `duty`=0 and goes to IDLE. Disable takes priority over a tick in the same cycle.
- **`duty_min` >= `duty_max`:** no error. The FSM still cycles; each ramp completes in one tick, so `duty` alternates between the latched `duty_max` and `duty_min`.
- **Invariant:** `duty` never wraps and stays within [min(`duty_min`,`duty_max`), max(`duty_min`,`duty_max`)] while not in IDLE.

## Timing
- All outputs are registered.
- `duty`, `state` and `direction` change only on the clock edge where `period_start`=1, and are visible the following cycle. The PWM core applies the new duty at its next period start.
- `cycle_done` is high for exactly one cycle, the cycle after the qualifying edge.
- Latency from `enable` rising to first `duty` update: up to one PWM period (wait for `period_start`) plus 1 clk.
- An asynchronous reset mid-ramp forces the reset values immediately. Restart requires `enable` plus a `period_start`.

## Test plan
- **Basic profile:** min=10, max=40, step=10, ppt=1, hold_high=2, hold_low=1, enable=1 -> after IDLE exit `duty`=10. Over the next ten period_starts `duty` = 20,30,40,40,40,30,20,10,10,20. `cycle_done` pulses once, at the 8th tick.
- **Prescale:** ppt=4, same config -> `duty` changes only on every 4th `period_start`. ppt=0 behaves as ppt=1.
- **Saturation:** min=0, max=65535, step=200, starting from `duty`=65500 -> next tick `duty`=65535, no wrap. Ramp-down from 150 with min=0 -> 0, no underflow.
- **Config latch:** change `max` from 40 to 20 during RAMP_UP -> the peak is still 40. The new max (20) applies only after `cycle_done`.
- **Disable and reset:** drop `enable` in HOLD_HI -> at the next `period_start`, `duty`=0 and `state`=IDLE. Assert `rst_n`=0 mid-RAMP_DN -> all outputs return to reset values immediately.
- **Degenerate config:** step=0 ramps by 1. Set min=30, max=20 -> `duty` alternates 20/30 per tick, and `cycle_done` pulses each time `duty` returns to 30.

Source files
------------

// File: rtl/pwm_fade_sequencer_if.sv
// Control, limit and duty bundle between the envelope
// controller and the PWM fade sequencer.
interface pwm_fade_sequencer_if #(
  parameter int DUTY_W = 16,
  parameter int CNT_W  = 8
);
  logic              enable;
  logic              period_start;
  logic [DUTY_W-1:0] duty_min;
  logic [DUTY_W-1:0] duty_max;
  logic [CNT_W-1:0]  step;
  logic [CNT_W-1:0]  periods_per_tick;
  logic [CNT_W-1:0]  hold_high;
  logic [CNT_W-1:0]  hold_low;
  logic [DUTY_W-1:0] duty;
  logic              direction;
  logic [2:0]        state;
  logic              cycle_done;

  modport master (
    output enable, period_start,
    output duty_min, duty_max, step,
    output periods_per_tick, hold_high, hold_low,
    input  duty, direction, state, cycle_done
  );

  modport slave (
    input  enable, period_start,
    input  duty_min, duty_max, step,
    input  periods_per_tick, hold_high, hold_low,
    output duty, direction, state, cycle_done
  );
endinterface

// File: rtl/pwm_fade_sequencer.sv
// Trapezoidal duty envelope for the PWM core; every
// duty update lands on a PWM period boundary.
module pwm_fade_sequencer #(
  parameter int DUTY_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  pwm_fade_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RAMP_UP = 3'd1,
    HOLD_HI = 3'd2,
    RAMP_DN = 3'd3,
    HOLD_LO = 3'd4
  } state_t;

  state_t            st, st_n;
  logic [DUTY_W-1:0] duty_q, duty_n;
  logic [DUTY_W-1:0] c_min, c_max;
  logic [CNT_W-1:0]  c_step, c_ppt;
  logic [CNT_W-1:0]  c_hh, c_hl;
  logic [CNT_W-1:0]  pcnt, pcnt_n;
  logic [CNT_W-1:0]  hcnt, hcnt_n;
  logic              done_q, done_n;
  logic              dir_q, ld, tick;
  logic [DUTY_W:0]   up_sum, dn_lim;

  // step and ppt are stored already clamped to >= 1
  assign tick = bus.period_start &&
                (pcnt == c_ppt - CNT_W'(1));

  assign up_sum = {1'b0, duty_q} +
                  (DUTY_W+1)'(c_step);
  assign dn_lim = {1'b0, c_min} +
                  (DUTY_W+1)'(c_step);

  always_comb begin
    st_n   = st;
    duty_n = duty_q;
    pcnt_n = pcnt;
    hcnt_n = hcnt;
    done_n = 1'b0;
    ld     = 1'b0;
    if (st != IDLE && bus.period_start)
      pcnt_n = tick ? '0 : pcnt + CNT_W'(1);
    unique case (st)
      IDLE: begin
        if (bus.enable && bus.period_start) begin
          ld     = 1'b1;
          duty_n = bus.duty_min;
          pcnt_n = '0;
          st_n   = RAMP_UP;
        end
      end
      RAMP_UP: begin
        if (tick) begin
          if (up_sum >= {1'b0, c_max}) begin
            duty_n = c_max;
            hcnt_n = '0;
            st_n   = (c_hh == '0) ? RAMP_DN : HOLD_HI;
          end else begin
            duty_n = up_sum[DUTY_W-1:0];
          end
        end
      end
      HOLD_HI: begin
        if (tick) begin
          if (hcnt == c_hh - CNT_W'(1))
            st_n = RAMP_DN;
          else
            hcnt_n = hcnt + CNT_W'(1);
        end
      end
      RAMP_DN: begin
        if (tick) begin
          if ({1'b0, duty_q} <= dn_lim) begin
            duty_n = c_min;
            done_n = 1'b1;
            ld     = 1'b1;
            hcnt_n = '0;
            // hold_low is being relatched on this edge
            st_n   = (bus.hold_low == '0) ? RAMP_UP
                                          : HOLD_LO;
          end else begin
            duty_n = duty_q - DUTY_W'(c_step);
          end
        end
      end
      HOLD_LO: begin
        if (tick) begin
          if (hcnt == c_hl - CNT_W'(1))
            st_n = RAMP_UP;
          else
            hcnt_n = hcnt + CNT_W'(1);
        end
      end
      default: st_n = IDLE;
    endcase
    if (st != IDLE && !bus.enable && bus.period_start) begin
      st_n   = IDLE;
      duty_n = '0;
      done_n = 1'b0;
      ld     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st     <= IDLE;
      duty_q <= '0;
      pcnt   <= '0;
      hcnt   <= '0;
      done_q <= 1'b0;
      dir_q  <= 1'b0;
    end else begin
      st     <= st_n;
      duty_q <= duty_n;
      pcnt   <= pcnt_n;
      hcnt   <= hcnt_n;
      done_q <= done_n;
      dir_q  <= (st_n == RAMP_UP) || (st_n == HOLD_HI);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_min  <= '0;
      c_max  <= '0;
      c_step <= '0;
      c_ppt  <= '0;
      c_hh   <= '0;
      c_hl   <= '0;
    end else if (ld) begin
      c_min  <= bus.duty_min;
      c_max  <= bus.duty_max;
      c_step <= (bus.step == '0) ? CNT_W'(1) : bus.step;
      c_ppt  <= (bus.periods_per_tick == '0) ? CNT_W'(1)
                : bus.periods_per_tick;
      c_hh   <= bus.hold_high;
      c_hl   <= bus.hold_low;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.state      = st;
  assign bus.direction  = dir_q;
  assign bus.cycle_done = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// Bench for pwm_fade_sequencer: envelope model plus
// directed literal checks of the fade profile.
module tb_pwm_fade_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pwm_fade_sequencer_if #(.DUTY_W(16), .CNT_W(8)) ifc();

  pwm_fade_sequencer #(.DUTY_W(16), .CNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int total = 0;
  int bad   = 0;
  int done_seen = 0;

  int m_st, m_duty, m_done, m_pc, m_hc;
  int c_min, c_max, c_step, c_ppt, c_hh, c_hl;

  int basic[10] = '{20, 30, 40, 40, 40, 30, 20, 10, 10, 20};
  int pre[8]    = '{10, 10, 10, 20, 20, 20, 20, 30};
  int lat[7]    = '{40, 40, 30, 20, 10, 10, 20};
  int dwn[6]    = '{20, 30, 40, 40, 40, 30};
  int deg[4]    = '{20, 30, 20, 30};

  task automatic chk(input string nm, input int act,
                     input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_duty = 0; m_done = 0;
    m_pc = 0; m_hc = 0;
    c_min = 0; c_max = 0; c_step = 0;
    c_ppt = 0; c_hh = 0; c_hl = 0;
  endtask

  task automatic latch();
    c_min  = ifc.duty_min;
    c_max  = ifc.duty_max;
    c_step = (ifc.step == 0) ? 1 : int'(ifc.step);
    c_ppt  = (ifc.periods_per_tick == 0) ? 1
             : int'(ifc.periods_per_tick);
    c_hh   = ifc.hold_high;
    c_hl   = ifc.hold_low;
  endtask

  // Envelope rules applied once per clock edge
  task automatic model();
    m_done = 0;
    if (!rst_n) begin
      model_reset();
      return;
    end
    if (!ifc.period_start) return;
    if (m_st == 0) begin
      if (ifc.enable) begin
        latch();
        m_duty = c_min;
        m_pc = 0;
        m_st = 1;
      end
      return;
    end
    if (!ifc.enable) begin
      m_st = 0;
      m_duty = 0;
      return;
    end
    m_pc++;
    if (m_pc < c_ppt) return;
    m_pc = 0;
    case (m_st)
      1: if (m_duty + c_step >= c_max) begin
           m_duty = c_max;
           m_hc = 0;
           m_st = (c_hh > 0) ? 2 : 3;
         end else m_duty = m_duty + c_step;
      2: begin
           m_hc++;
           if (m_hc >= c_hh) m_st = 3;
         end
      3: if (m_duty <= c_min + c_step) begin
           m_duty = c_min;
           m_done = 1;
           latch();
           m_hc = 0;
           m_st = (c_hl > 0) ? 4 : 1;
         end else m_duty = m_duty - c_step;
      4: begin
           m_hc++;
           if (m_hc >= c_hl) m_st = 1;
         end
      default: m_st = 0;
    endcase
  endtask

  always @(negedge clk) begin
    chk("duty", ifc.duty, m_duty);
    chk("state", ifc.state, m_st);
    chk("direction", ifc.direction,
        (m_st == 1 || m_st == 2) ? 1 : 0);
    chk("cycle_done", ifc.cycle_done, m_done);
    if (ifc.cycle_done) done_seen <= done_seen + 1;
  end

  task automatic clk_step();
    @(posedge clk);
    model();
    #2;
  endtask

  task automatic ps_period();
    ifc.period_start = 1'b1;
    clk_step();
    ifc.period_start = 1'b0;
    clk_step();
    clk_step();
  endtask

  task automatic expect_duty(input string nm, input int e);
    ps_period();
    chk(nm, ifc.duty, e);
  endtask

  task automatic cfg(input int mn, input int mx,
                     input int st, input int ppt,
                     input int hh, input int hl);
    ifc.duty_min = 16'(mn);
    ifc.duty_max = 16'(mx);
    ifc.step = 8'(st);
    ifc.periods_per_tick = 8'(ppt);
    ifc.hold_high = 8'(hh);
    ifc.hold_low = 8'(hl);
  endtask

  task automatic disable_run();
    ifc.enable = 1'b0;
    ps_period();
    chk("disable_state", ifc.state, 0);
    chk("disable_duty", ifc.duty, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, done_at;
    model_reset();
    ifc.enable = 1'b0;
    ifc.period_start = 1'b0;
    cfg(10, 40, 10, 1, 2, 1);
    repeat (3) clk_step();
    chk("rst_duty", ifc.duty, 0);
    chk("rst_state", ifc.state, 0);
    chk("rst_done", ifc.cycle_done, 0);
    rst_n = 1'b1;
    clk_step();

    ifc.enable = 1'b1;
    expect_duty("basic_exit", 10);
    chk("basic_exit_state", ifc.state, 1);
    done_at = 0;
    for (int i = 0; i < 10; i++) begin
      d0 = done_seen;
      expect_duty("basic_seq", basic[i]);
      if (done_seen != d0) done_at = i + 1;
    end
    chk("basic_done_count", done_seen, 1);
    chk("basic_done_tick", done_at, 8);

    expect_duty("to_hold_a", 30);
    expect_duty("to_hold_b", 40);
    chk("hold_hi_state", ifc.state, 2);
    disable_run();

    cfg(10, 40, 10, 4, 2, 1);
    ifc.enable = 1'b1;
    expect_duty("pre_exit", 10);
    for (int i = 0; i < 8; i++)
      expect_duty("prescale4", pre[i]);
    disable_run();

    cfg(10, 40, 10, 0, 2, 1);
    ifc.enable = 1'b1;
    expect_duty("ppt0_exit", 10);
    expect_duty("ppt0_tick", 20);
    disable_run();

    cfg(10, 40, 10, 1, 2, 1);
    ifc.enable = 1'b1;
    expect_duty("lat_exit", 10);
    expect_duty("lat_p1", 20);
    ifc.duty_max = 16'd20;
    expect_duty("lat_p2", 30);
    expect_duty("lat_peak", 40);
    for (int i = 0; i < 7; i++)
      expect_duty("lat_seq", lat[i]);
    chk("lat_new_max_state", ifc.state, 2);
    ifc.duty_max = 16'd40;
    disable_run();

    ifc.enable = 1'b1;
    expect_duty("dn_exit", 10);
    for (int i = 0; i < 6; i++)
      expect_duty("dn_seq", dwn[i]);
    chk("dn_state", ifc.state, 3);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_duty", ifc.duty, 0);
    chk("async_rst_state", ifc.state, 0);
    chk("async_rst_dir", ifc.direction, 0);
    clk_step();
    clk_step();
    rst_n = 1'b1;
    clk_step();
    chk("no_restart_without_ps", ifc.state, 0);
    ifc.enable = 1'b0;
    clk_step();

    cfg(65500, 65535, 200, 1, 0, 0);
    ifc.enable = 1'b1;
    expect_duty("sat_exit", 65500);
    expect_duty("sat_top", 65535);
    chk("sat_skip_hold", ifc.state, 3);
    expect_duty("sat_back", 65500);
    chk("sat_skip_lo", ifc.state, 1);
    disable_run();

    cfg(0, 150, 200, 1, 0, 0);
    ifc.enable = 1'b1;
    expect_duty("uf_exit", 0);
    expect_duty("uf_top", 150);
    expect_duty("uf_bottom", 0);
    disable_run();

    cfg(10, 13, 0, 1, 0, 0);
    ifc.enable = 1'b1;
    expect_duty("step0_exit", 10);
    expect_duty("step0_a", 11);
    expect_duty("step0_b", 12);
    disable_run();

    cfg(30, 20, 10, 1, 0, 0);
    ifc.enable = 1'b1;
    expect_duty("deg_exit", 30);
    d0 = done_seen;
    for (int i = 0; i < 4; i++)
      expect_duty("deg_seq", deg[i]);
    chk("deg_done_count", done_seen - d0, 2);
    disable_run();

    clk_step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
